ham_15_11_dec_pipe: RTL
=======================

// Module: ham_15_11_dec_pipe
// PURPOSE
//  Pipelined Hamming (15,11) single-error-correcting decoder; consumes 15-bit
//  codewords produced by ham_15_11_enc after storage/transport and returns the
//  11-bit payload. Valid/ready streaming interface with full backpressure; keeps
//  a saturating count of words that needed correction, for TMR/SEU monitoring.
// PARAMETERS
//  CNT_W  16  width of the corrected-word counter err_cnt_o
// PORTS
//  clk_i        in   1      system clock, all logic rising-edge
//  rst_n_i      in   1      asynchronous active-low reset
//  din_i        in   15     codeword; bit k = Hamming position k+1
//  din_valid_i  in   1      din_i valid
//  din_ready_o  out  1      decoder can accept din_i this cycle
//  dout_o       out  11     decoded (corrected) payload
//  dout_valid_o out  1      dout_o/err_o/dcorr_o/synd_o valid
//  dout_ready_i in   1      downstream accepts dout_o
//  err_o        out  1      word had nonzero syndrome (single-bit error fixed)
//  dcorr_o      out  1      corrected bit was a data bit (not a parity bit)
//  synd_o       out  4      syndrome = flipped position (0 = clean)
//  cnt_clr_i    in   1      synchronous clear of err_cnt_o
//  err_cnt_o    out  CNT_W  saturating count of accepted words with err_o=1
// BEHAVIOUR
//  - Reset (rst_n_i low, async): both stage valids 0, all outputs 0,
//    err_cnt_o 0; din_ready_o = 1 as soon as reset releases.
//  - Bit map: parity at positions 1,2,4,8 (bits 0,1,3,7); data d0..d10 at
//    positions 3,5,6,7,9,10,11,12,13,14,15 in ascending order. Must match
//    ham_15_11_enc.
//  - Stage 1: register codeword and syndrome s[j] = XOR of din bits whose
//    position has bit j set (j=0..3).
//  - Stage 2: if s!=0 invert codeword bit s-1; extract d0..d10 to dout_o;
//    err_o = (s!=0); dcorr_o = s not in {0,1,2,4,8}; synd_o = s.
//  - Latency: 2 cycles from accepted input to dout_valid_o, no stalls.
//    Throughput: 1 word/cycle.
//  - Handshake: transfer when valid & ready are both high on a clock edge.
//    en = !dout_valid_o | dout_ready_i; din_ready_o = en (combinational).
//    When en=0 both stages hold; dout_o and flags are stable while
//    dout_valid_o=1 and dout_ready_i=0. Bubbles in stage 1 are not
//    compressed (simple global stall).
//  - dout_valid_o never depends combinationally on dout_ready_i. din_valid_i
//    may drop without handshake; no word is duplicated or lost.
//  - Counter: +1 on each output transfer with err_o=1. Saturates at
//    2^CNT_W-1, no wrap. cnt_clr_i takes priority over a same-cycle
//    increment (result 0).
//  - Every nonzero syndrome is treated as correctable (perfect code).
//    Double errors miscorrect silently; detecting them is out of scope.
// TESTING
//  1. Reset, din 15'h6350 valid, dout_ready_i=1 -> 2 cycles later dout 11'h63A,
//     err 0, synd 0, cnt 0.
//  2. din 15'h6250 (pos 9 flipped) -> dout 11'h63A, err 1, dcorr 1, synd 9,
//     cnt 1.
//  3. din 15'h6351 (parity pos 1 flipped) -> dout 11'h63A, err 1, dcorr 0,
//     synd 1; 15'h0000 -> dout 0, err 0.
//  4. Stream 8 words, dout_ready_i low for 3 cycles mid-stream -> all 8 out,
//     in order, output held stable during stall, din_ready_o low while stalled.
//  5. CNT_W=2, 5 erroneous words -> cnt saturates at 3. cnt_clr_i together
//     with an error transfer -> cnt 0.
//  6. Exhaustive: all 2^11 payloads x 16 error positions (none + 15) -> dout
//     equals payload every time. Assert rst_n_i mid-stream -> outputs 0
//     immediately; first post-reset word decodes correctly.

Source files
------------

// File: rtl/ham_15_11_dec_pipe.sv
// Two-stage pipelined Hamming (15,11) SEC decoder with valid/ready streaming,
// global stall backpressure and a saturating corrected-word counter.
`default_nettype none

module ham_15_11_dec_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [14:0]      din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic [10:0]      dout_o,
    output logic             dout_valid_o,
    input  logic             dout_ready_i,
    output logic             err_o,
    output logic             dcorr_o,
    output logic [3:0]       synd_o,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] err_cnt_o
);

    logic        en;
    logic        v1;
    logic [14:0] cw1;
    logic [3:0]  s1;
    logic [3:0]  synd_c;
    logic [14:0] fixed_c;
    logic [10:0] data_c;

    // Both stages advance together whenever the output slot is free or draining.
    assign en          = !dout_valid_o || dout_ready_i;
    assign din_ready_o = en;

    always_comb begin
        synd_c = '0;
        for (int k = 0; k < 15; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (((k + 1) & (1 << j)) != 0) begin
                    synd_c[j] = synd_c[j] ^ din_i[k];
                end
            end
        end
    end

    always_comb begin
        fixed_c = cw1;
        if (s1 != 4'd0) begin
            fixed_c[s1 - 4'd1] = ~cw1[s1 - 4'd1];
        end
        // Data occupies every non-power-of-two position, ascending.
        data_c = {fixed_c[14:8], fixed_c[6:4], fixed_c[2]};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1  <= 1'b0;
            cw1 <= '0;
            s1  <= '0;
        end else if (en) begin
            v1 <= din_valid_i;
            if (din_valid_i) begin
                cw1 <= din_i;
                s1  <= synd_c;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dout_valid_o <= 1'b0;
            dout_o       <= '0;
            err_o        <= 1'b0;
            dcorr_o      <= 1'b0;
            synd_o       <= '0;
        end else if (en) begin
            dout_valid_o <= v1;
            if (v1) begin
                dout_o  <= data_c;
                err_o   <= (s1 != 4'd0);
                dcorr_o <= ((s1 & (s1 - 4'd1)) != 4'd0);
                synd_o  <= s1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            err_cnt_o <= '0;
        end else if (dout_valid_o && dout_ready_i && err_o && (err_cnt_o != {CNT_W{1'b1}})) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

endmodule

`default_nettype wire
